stage_execute_mc: RTL

//  Parametrised execute stage: single-cycle ALU (add/sub/logic/shift), link/jump address

---
 rtl/stage_execute_mc.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stage_execute_mc.sv
// stage_execute_mc: execute stage with a single-cycle ALU, jump/link and memory
// address generation, and an iterative shift-add multiplier. The multiplier
// stalls upstream through a small IDLE/BUSY/DONE FSM.
// Optional feature: define STAGE_EXECUTE_MC_DIV_EN to add a restoring divider
// for aluop A (divu) and B (remu). When it is undefined those opcodes return 0
// in a single cycle.
module stage_execute_mc #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 4,
    parameter int RET_OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   pc,
    input  logic              valid_in,
    input  logic              stall_in,
    output logic              stall,
    input  logic [REG_AW-1:0] dest,
    input  logic [3:0]        aluop,
    input  logic [XLEN-1:0]   reg_a,
    input  logic [XLEN-1:0]   reg_b,
    input  logic [XLEN-1:0]   reg_m,
    input  logic              is_mem_in,
    input  logic              mem_write_in,
    input  logic              is_jump,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [XLEN-1:0]   fwd_val,
    output logic              jump,
    output logic [XLEN-1:0]   jump_addr,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_addr,
    output logic [XLEN-1:0]   out_val,
    output logic              is_mem,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_val,
    output logic              mem_write
);

    localparam int SHW = $clog2(XLEN);
`ifdef STAGE_EXECUTE_MC_DIV_EN
    localparam int OPW = 2;   // bit 1: divide step, bit 0: take upper accumulator
`else
    localparam int OPW = 1;   // bit 0: take upper accumulator (mulhu)
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              out_valid_q, out_valid_d;
    logic [REG_AW-1:0] out_addr_q, out_addr_d;
    logic [XLEN-1:0]   out_val_q, out_val_d;
    logic              is_mem_q, is_mem_d;

    logic              mc_op;
    logic [XLEN-1:0]   sum_ab;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   mc_result;
    logic [XLEN-1:0]   result;
    logic [XLEN:0]     mul_sum;
`ifdef STAGE_EXECUTE_MC_DIV_EN
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_sub;
    logic              div_ge;
`endif

    // Multi-cycle ops: mul/mulhu, plus divu/remu when the divider is built.
`ifdef STAGE_EXECUTE_MC_DIV_EN
    assign mc_op = valid_in & ~is_jump & (aluop[3:2] == 2'b10);
`else
    assign mc_op = valid_in & ~is_jump & (aluop[3:1] == 3'b100);
`endif

    assign sum_ab = reg_a + reg_b;
    assign shamt  = reg_b[SHW-1:0];

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole {carry, hi, lo} accumulator right by one.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

`ifdef STAGE_EXECUTE_MC_DIV_EN
    // One restoring-divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. A zero divisor always
    // "fits", which naturally yields all-ones quotient and remainder = dividend.
    assign rem_sh  = {acc_hi_q, acc_lo_q[XLEN-1]};
    assign div_ge  = (rem_sh >= {1'b0, opb_q});
    assign rem_sub = rem_sh[XLEN-1:0] - opb_q;
`endif

    // Low half holds product-low / quotient, high half product-high / remainder.
    assign mc_result = op_q[0] ? acc_hi_q : acc_lo_q;

    // Single-cycle ALU; a jump overrides the opcode with the link value.
    always_comb begin
        alu_result = '0;
        if (is_jump) begin
            alu_result = pc + XLEN'(RET_OFFSET);
        end else begin
            case (aluop)
                4'h0:    alu_result = sum_ab;
                4'h1:    alu_result = reg_a - reg_b;
                4'h2:    alu_result = reg_a & reg_b;
                4'h3:    alu_result = reg_a | reg_b;
                4'h4:    alu_result = reg_a ^ reg_b;
                4'h5:    alu_result = reg_a << shamt;
                4'h6:    alu_result = reg_a >> shamt;
                4'h7:    alu_result = XLEN'($signed(reg_a) >>> shamt);
                default: alu_result = '0;
            endcase
        end
    end

    // FSM next state, iterative datapath step, stall/forward and output capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opb_d       = opb_q;
        op_d        = op_q;
        dest_d      = dest_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_val_d   = out_val_q;
        is_mem_d    = is_mem_q;
        stall       = stall_in;
        fwd_valid   = 1'b0;
        result      = alu_result;

        case (state_q)
            ST_IDLE: begin
                if (mc_op) begin
                    stall    = 1'b1;
                    state_d  = ST_BUSY;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = reg_a;
                    opb_d    = reg_b;
                    op_d     = aluop[OPW-1:0];
                    dest_d   = dest;
                end else begin
                    fwd_valid = valid_in & ~is_mem_in;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
`ifdef STAGE_EXECUTE_MC_DIV_EN
                if (op_q[1]) begin
                    if (div_ge) begin
                        acc_hi_d = rem_sub;
                        acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_sh[XLEN-1:0];
                        acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[XLEN:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
                end
`else
                acc_hi_d = mul_sum[XLEN:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
`endif
                if (cnt_q == SHW'(XLEN - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result    = mc_result;
                fwd_valid = valid_in & ~is_mem_in;
                if (!stall_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stalled cycles send a bubble downstream but keep the last value.
        if (stall) begin
            out_valid_d = 1'b0;
            out_addr_d  = '0;
            is_mem_d    = 1'b0;
        end else begin
            out_valid_d = valid_in;
            out_addr_d  = (state_q == ST_DONE) ? dest_q : dest;
            out_val_d   = result;
            is_mem_d    = is_mem_in;
        end
    end

    // State and pipeline registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            dest_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_val_q   <= '0;
            is_mem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_val_q   <= out_val_d;
            is_mem_q    <= is_mem_d;
        end
    end

    assign fwd_addr  = dest;
    assign fwd_val   = result;
    assign jump      = valid_in & is_jump;
    assign jump_addr = sum_ab;
    assign mem_addr  = sum_ab;
    assign mem_val   = reg_m;
    assign mem_write = mem_write_in;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_val   = out_val_q;
    assign is_mem    = is_mem_q;

endmodule
